// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcode/aluop codes,
// instruction field positions and the mult/div sequencer state type.
package pipe_ctrl_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;

    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 27;
    localparam int unsigned RD_HI    = 26;
    localparam int unsigned RD_LO    = 22;
    localparam int unsigned RS_HI    = 21;
    localparam int unsigned RS_LO    = 17;
    localparam int unsigned RT_HI    = 16;
    localparam int unsigned RT_LO    = 12;
    localparam int unsigned ALUOP_HI = 6;
    localparam int unsigned ALUOP_LO = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the FD and DX instruction registers into the
// register-usage and class flags needed for hazard detection.
module hazard_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    output logic        fd_rs_used,
    output logic [4:0]  fd_rs,
    output logic [4:0]  fd_src2,
    output logic        fd_src2_used,
    output logic        dx_is_lw,
    output logic        dx_is_md,
    output logic [4:0]  dx_rd
);

    logic [4:0] fd_op;
    logic [4:0] dx_op;
    logic [4:0] dx_aluop;
    logic       unused_bits;

    assign fd_op       = fd_ir[OPC_HI:OPC_LO];
    assign dx_op       = dx_ir[OPC_HI:OPC_LO];
    assign dx_aluop    = dx_ir[ALUOP_HI:ALUOP_LO];
    assign unused_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    always_comb begin
        fd_rs        = fd_ir[RS_HI:RS_LO];
        fd_rs_used   = !(fd_op == OP_J || fd_op == OP_JAL || fd_op == OP_SETX);
        fd_src2      = '0;
        fd_src2_used = 1'b0;
        // sw reads its data register through the rd field
        if (fd_op == OP_SW) begin
            fd_src2      = fd_ir[RD_HI:RD_LO];
            fd_src2_used = 1'b1;
        end else if (fd_op == OP_ALU) begin
            fd_src2      = fd_ir[RT_HI:RT_LO];
            fd_src2_used = 1'b1;
        end
        dx_rd    = dx_ir[RD_HI:RD_LO];
        dx_is_lw = (dx_op == OP_LW);
        dx_is_md = (dx_op == OP_ALU) && (dx_aluop == ALUOP_MUL || dx_aluop == ALUOP_DIV);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller and mult/div sequencer for the 5-stage pipeline.
// Define PIPE_PERF_CNT_EN to build the saturating stall_cycles counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 40,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        branch_taken,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        dx_bubble,
    output logic        fd_flush,
    output logic        xm_bubble,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [31:0] stall_cycles
);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] md_cnt, cnt_nxt;

    logic       fd_rs_used, fd_src2_used, dx_is_lw, dx_is_md;
    logic [4:0] fd_rs, fd_src2, dx_rd;
    logic       load_use;

    hazard_decode u_decode (
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .fd_rs_used   (fd_rs_used),
        .fd_rs        (fd_rs),
        .fd_src2      (fd_src2),
        .fd_src2_used (fd_src2_used),
        .dx_is_lw     (dx_is_lw),
        .dx_is_md     (dx_is_md),
        .dx_rd        (dx_rd)
    );

    assign load_use = dx_is_lw && (dx_rd != '0) &&
                      ((fd_rs_used && fd_rs == dx_rd) || (fd_src2_used && fd_src2 == dx_rd));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= cnt_nxt;
        end
    end

    // Outputs are gated by reset directly so they drop without waiting for a clock edge
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = md_cnt;
        pc_we      = 1'b1;
        fd_we      = 1'b1;
        dx_we      = 1'b1;
        dx_bubble  = 1'b0;
        fd_flush   = 1'b0;
        xm_bubble  = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_timeout = 1'b0;
        if (!reset) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_we     = 1'b0;
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dx_is_md) begin
                        md_start  = 1'b1;
                        state_nxt = MD_RUN;
                        cnt_nxt   = '0;
                    end
                    if (branch_taken) begin
                        fd_flush  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_we     = 1'b0;
                        fd_we     = 1'b0;
                        dx_bubble = 1'b1;
                    end
                end
                MD_RUN: begin
                    md_busy   = 1'b1;
                    cnt_nxt   = md_cnt + 1'b1;
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_we     = 1'b0;
                    xm_bubble = 1'b1;
                    if (md_ready) begin
                        state_nxt = MD_DONE;
                    end else if (md_cnt == CNT_W'(MD_TIMEOUT - 1)) begin
                        md_timeout = 1'b1;
                        state_nxt  = MD_DONE;
                    end
                end
                MD_DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_cnt;
    logic [1:0]  perf_inc;

    assign perf_inc = {1'b0, ~pc_we} +
                      {1'b0, (state == MD_RUN) && md_ready && md_exception};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_cnt <= '0;
        end else if (perf_cnt > (32'hFFFF_FFFF - 32'(perf_inc))) begin
            perf_cnt <= '1;
        end else begin
            perf_cnt <= perf_cnt + 32'(perf_inc);
        end
    end

    assign stall_cycles = perf_cnt;
`else
    logic unused_exc;
    assign unused_exc   = md_exception;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised plus directed scoreboard bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TMO = 40;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_ir = '0;
    logic [31:0] dx_ir = '0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic        pc_we, fd_we, dx_we, dx_bubble, fd_flush, xm_bubble;
    logic        md_start, md_busy, md_timeout;
    logic [31:0] stall_cycles;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .pc_we        (pc_we),
        .fd_we        (fd_we),
        .dx_we        (dx_we),
        .dx_bubble    (dx_bubble),
        .fd_flush     (fd_flush),
        .xm_bubble    (xm_bubble),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic [8:0]  ctl;
        logic [31:0] stall;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: mult/div progress as plain flags and a run length
    bit              m_run = 1'b0;
    bit              m_done = 1'b0;
    int unsigned     m_len = 0;
    longint unsigned m_perf = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, rd, rs);
        return {op, rd, rs, 17'h0};
    endfunction

    function automatic bit is_md(input logic [31:0] ir);
        return ir[31:27] == 5'b00000 && (ir[6:2] == 5'b00110 || ir[6:2] == 5'b00111);
    endfunction

    function automatic bit reads(input logic [31:0] f, input logic [4:0] r);
        logic [4:0] op;
        bit hit;
        op  = f[31:27];
        hit = 1'b0;
        if (!(op == 5'b00001 || op == 5'b00011 || op == 5'b10101) && f[21:17] == r) hit = 1'b1;
        if (op == 5'b00111 && f[26:22] == r) hit = 1'b1;
        if (op == 5'b00000 && f[16:12] == r) hit = 1'b1;
        return hit;
    endfunction

    function automatic longint unsigned sat_inc(input longint unsigned v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    task automatic cyc(input logic [31:0] f, d, input bit br, rdy, exc, rst);
        exp_t e;
        bit pc, fdw, dxw, dxb, ffl, xmb, st, bsy, tmo;
        @(posedge clock);
        #1;
        if (rst) begin
            reset = 1'b0;
            fd_ir = '0; dx_ir = '0;
            branch_taken = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
            m_run = 1'b0; m_done = 1'b0; m_len = 0; m_perf = 0;
            exp_q.push_back('0);
            @(negedge clock);
            #1;
            reset = 1'b1;
            return;
        end
        fd_ir = f; dx_ir = d;
        branch_taken = br; md_ready = rdy; md_exception = exc;
        e.stall = PERF ? 32'(m_perf) : 32'h0;
        pc = 1; fdw = 1; dxw = 1; dxb = 0; ffl = 0; xmb = 0; st = 0; bsy = 0; tmo = 0;
        if (m_run) begin
            bsy = 1; pc = 0; fdw = 0; dxw = 0; xmb = 1;
            m_len = m_len + 1;
            if (rdy) begin
                m_run = 0; m_done = 1;
                if (exc) m_perf = sat_inc(m_perf);
            end else if (m_len == TMO) begin
                tmo = 1; m_run = 0; m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else begin
            if (is_md(d)) begin
                st = 1; m_run = 1; m_len = 0;
            end
            if (br) begin
                ffl = 1; dxb = 1;
            end else if (d[31:27] == 5'b01000 && d[26:22] != 5'd0 && reads(f, d[26:22])) begin
                pc = 0; fdw = 0; dxb = 1;
            end
        end
        if (!pc) m_perf = sat_inc(m_perf);
        e.ctl = {pc, fdw, dxw, dxb, ffl, xmb, st, bsy, tmo};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_we, fd_we, dx_we, dx_bubble, fd_flush, xm_bubble, md_start, md_busy, md_timeout};
                n_cmp++;
                if (act !== e.ctl) begin
                    n_bad++;
                    $display("FAIL ctl @%0t: got %b want %b (pc fd dx dxb ffl xmb st busy tmo)", $time, act, e.ctl);
                end
                n_cmp++;
                if (stall_cycles !== e.stall) begin
                    n_bad++;
                    $display("FAIL stall_cycles @%0t: got %0d want %0d", $time, stall_cycles, e.stall);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] mul_ir, div_ir, add_dep, f, d;
        mul_ir  = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
        div_ir  = rtype(5'd4, 5'd1, 5'd2, 5'b00111);
        add_dep = rtype(5'd6, 5'd5, 5'd2, 5'b00000);

        cyc('0, '0, 0, 0, 0, 1);
        // load-use on r5, then pipeline advanced
        cyc(add_dep, itype(5'b01000, 5'd5, 5'd1), 0, 0, 0, 0);
        cyc(add_dep, 32'h0, 0, 0, 0, 0);
        // lw to r0 never stalls
        cyc(rtype(5'd6, 5'd0, 5'd2, 5'd0), itype(5'b01000, 5'd0, 5'd1), 0, 0, 0, 0);
        // sw data dependency, then independent add
        cyc(itype(5'b00111, 5'd7, 5'd3), itype(5'b01000, 5'd7, 5'd1), 0, 0, 0, 0);
        cyc(rtype(5'd8, 5'd9, 5'd10, 5'd0), itype(5'b01000, 5'd7, 5'd1), 0, 0, 0, 0);
        // mul finishing on the 17th run cycle
        cyc(32'h0, mul_ir, 0, 0, 0, 0);
        for (int i = 1; i <= 17; i++) cyc(32'h0, mul_ir, 0, (i == 17), 0, 0);
        cyc(32'h0, mul_ir, 0, 0, 0, 0);
        cyc(32'h0, 32'h0, 0, 0, 0, 0);
        // timeout with md_ready held low
        cyc(32'h0, div_ir, 0, 0, 0, 0);
        for (int i = 1; i <= 40; i++) cyc(32'h0, div_ir, 0, 0, 0, 0);
        cyc(32'h0, div_ir, 0, 0, 0, 0);
        cyc(32'h0, 32'h0, 0, 0, 0, 0);
        // branch beats load-use
        cyc(add_dep, itype(5'b01000, 5'd5, 5'd1), 1, 0, 0, 0);
        // md_ready/exception outside MD_RUN are ignored
        cyc(32'h0, 32'h0, 0, 1, 1, 0);
        // reset during the 5th run cycle
        cyc(32'h0, mul_ir, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(32'h0, mul_ir, 0, 0, 0, 0);
        cyc('0, '0, 0, 0, 0, 1);
        cyc(32'h0, 32'h0, 0, 0, 0, 0);
        cyc(add_dep, 32'h0, 0, 0, 0, 0);

        d = '0;
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] ra, rb, rc;
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rc = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: f = itype(5'b01000, ra, rb);
                1: f = itype(5'b00111, ra, rb);
                2: f = rtype(ra, rb, rc, 5'd0);
                3: f = itype(5'b00001, ra, rb);
                4: f = itype(5'b10101, ra, rb);
                5: f = itype(5'b00011, ra, rb);
                default: f = rtype(rc, ra, rb, 5'd1);
            endcase
            if (!(m_run || m_done)) begin
                ra = 5'($urandom_range(0, 7));
                case ($urandom_range(0, 9))
                    0, 1, 2: d = itype(5'b01000, ra, rb);
                    3: d = mul_ir;
                    4: d = div_ir;
                    5: d = itype(5'b00111, ra, rb);
                    6: d = 32'h0;
                    default: d = rtype(ra, rb, rc, 5'd0);
                endcase
            end
            if ($urandom_range(0, 299) == 0) begin
                cyc('0, '0, 0, 0, 0, 1);
                d = '0;
            end else begin
                cyc(f, d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)), 0);
            end
        end

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/sequencing controller for the 5-stage pipeline (F, D, X, M, W latches).
- Decodes the IRs held in the FD and DX latches, then generates the PC, FD and DX write enables and bubble/flush selects.
- Sequences the multicycle mult/div unit: start pulse, busy tracking, result handoff and timeout.
- Sits beside the latch chain. All outputs are valid before the latches' falling-edge capture.

Parameters:
MD_TIMEOUT, 40, cycles in MD_RUN before timeout is declared (must be at least 2 and fit in CNT_W bits)
CNT_W, 6, width of the mult/div cycle counter

Ports:
clock  in  1  system clock; controller state updates on the rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
fd_ir  in  32  IR output of the FD latch
dx_ir  in  32  IR output of the DX latch
branch_taken  in  1  taken branch/jump resolved in X for the instruction in DX
md_ready  in  1  mult/div result valid
md_exception  in  1  mult/div overflow or divide-by-zero, sampled with md_ready
pc_we  out  1  PC register write enable
fd_we  out  1  FD latch write enable
dx_we  out  1  DX latch write enable (0 = hold)
dx_bubble  out  1  select nop (32'h0) as DX IR_in
fd_flush  out  1  select nop as FD IR_in
xm_bubble  out  1  select nop as XM IR_in
md_start  out  1  one-cycle start pulse to mult/div
md_busy  out  1  high while in MD_RUN
md_timeout  out  1  one-cycle pulse when MD_TIMEOUT expires
stall_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- Opcode values: lw = 01000, sw = 00111, R-type = 00000. mul is R-type with aluop 00110; div is R-type with aluop 00111.
- Second source of the FD instruction:
  - rd when FD holds sw.
  - rt when FD holds R-type.
  - none otherwise.
  - rs is a source for all opcodes except j/jal/setx.
- FSM states are IDLE, MD_RUN and MD_DONE; encoding is 2 bits.
- IDLE:
  - If dx_ir is mul/div: md_start=1 for this cycle only; next state MD_RUN; counter <= 0.
- MD_RUN:
  - md_busy=1 and the counter increments each cycle.
  - pc_we=fd_we=dx_we=0 and xm_bubble=1.
  - If md_ready=1: next state MD_DONE.
  - Else if counter == MD_TIMEOUT-1: md_timeout=1 and next state MD_DONE.
- MD_DONE:
  - All enables are 1 and xm_bubble=0, so the mul/div advances to XM with its result.
  - Next state is IDLE.
  - A new mul/div arriving in DX on the following cycle restarts the sequence; no re-start occurs for the same instruction.
- Load-use stall, applies in IDLE only:
  - Condition: dx_ir is lw, dx rd != 0, and dx rd matches any FD source.
  - Response: pc_we=fd_we=0 and dx_bubble=1 for exactly one cycle.
- Branch flush, applies in IDLE only:
  - Condition: branch_taken=1.
  - Response: fd_flush=1 and dx_bubble=1, with pc_we=fd_we=1.
  - Takes priority over load-use; a stall is cancelled when its victim is flushed.
- Priority order: reset > MD_RUN freeze > branch flush > load-use > normal.
- Normal operation: pc_we=fd_we=dx_we=1; all other outputs 0.
- Register 0 never causes a hazard.
- Reset asserted (async, any state, including mid-MD_RUN):
  - State goes to IDLE and the counter to 0.
  - md_start, md_busy, md_timeout, all bubbles/flushes and stall_cycles are 0.
  - pc_we=fd_we=dx_we=0.
- Reset release: normal operation begins on the first rising edge.
- md_ready outside MD_RUN is ignored.
- md_exception is passed through by the datapath; the controller ignores it except under the Optional Feature.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles is a 32-bit counter that increments every cycle pc_we=0 while reset is deasserted.
  - It saturates at 32'hFFFFFFFF.
  - It also increments once per md_exception sampled with md_ready in MD_RUN.
- Undefined: stall_cycles is tied to 32'h0 and no counter flops are present.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - opcode and aluop localparams (OP_ALU, OP_LW, OP_SW, ALUOP_MUL, ALUOP_DIV);
  - the field-slice bit positions;
  - the md_state_t enum {IDLE, MD_RUN, MD_DONE}.
- Sub-module hazard_decode: purely combinational; takes fd_ir and dx_ir and returns fd_rs_used, fd_src2, fd_src2_used, dx_is_lw, dx_is_md and dx_rd. The FSM lives in the top module.

Test Plan:
- Load-use: DX=lw r5 ← 0(r1), FD=add r6,r5,r2 -> exactly one cycle of pc_we=fd_we=0 and dx_bubble=1, then normal; the same sequence with lw r0 -> no stall.
- sw dependency: DX=lw r7, FD=sw r7,0(r3) (rd=7) -> one-cycle stall; FD=add r8,r9,r10 -> no stall.
- mul: DX=mul, md_ready raised on the 17th MD_RUN cycle -> md_start pulses once; 17 cycles of md_busy with enables 0 and xm_bubble=1; then MD_DONE with enables 1; then IDLE.
- Timeout: mul in DX with md_ready held 0 -> md_timeout pulses on MD_RUN cycle 40, then MD_DONE, then IDLE.
- Branch vs load-use: branch_taken=1 with DX=lw r5 and FD reading r5 -> fd_flush=1, dx_bubble=1, pc_we=1 (no stall).
- Reset in MD_RUN: assert reset at MD_RUN cycle 5 -> md_busy=0 immediately; after release the state is IDLE and, with PIPE_PERF_CNT_EN defined, stall_cycles=0.
